// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//
// Purpose
//   Shares one cacheline adaptor (physical memory port) between an instruction
//   cache and a data cache.  One line transaction is in flight at a time.  When
//   both caches want the adaptor in the same IDLE cycle, the side that did not
//   win the previous grant goes first, so back-to-back contention alternates
//   I, D, I, D, ...
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   i_read, i_address              instruction-cache line read request
//   i_rdata, i_resp                line data / one-cycle completion to the I-cache
//   d_read, d_write, d_address,
//   d_wdata                        data-cache line read / writeback request
//   d_rdata, d_resp                line data / one-cycle completion to the D-cache
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata       line request to the adaptor (registered)
//   pmem_rdata, pmem_resp          line data / completion from the adaptor
//   busy                           high whenever a transaction is being served
//
// Handshake
//   A requester holds its read/write level high until it sees its resp pulse.
//   The arbiter samples requests only in IDLE; at the granting edge it copies
//   the winner's address, operation and (D only) write data into registers and
//   drives the adaptor from those registers until pmem_resp.  The cycle where
//   pmem_resp is high is the completion cycle: the owner's resp is high in
//   that same cycle and the FSM is back in IDLE on the next one.  pmem_resp
//   outside a serve state carries no meaning and is dropped.
// -----------------------------------------------------------------------------
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,

  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,

  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,

  output logic         busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]   state;
  logic         last_grant;   // 0 = I won last, 1 = D won last
  logic [31:0]  lat_addr;
  logic [255:0] lat_wdata;
  logic         lat_write;    // 1 = latched operation is a line write

  logic         want_i;
  logic         want_d;
  logic         grant_i;
  logic         grant_d;

  // ---------------------------------------------------------------------------
  // Arbitration.  Only meaningful in IDLE; the FSM ignores it elsewhere.
  // On a tie, D wins unless D was the last side granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    want_i  = i_read;
    want_d  = d_read | d_write;
    grant_d = want_d & (~want_i | ~last_grant);
    grant_i = want_i & ~grant_d;
  end

  // ---------------------------------------------------------------------------
  // FSM and request latches
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 256'd0;
      lat_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            last_grant <= 1'b1;
            lat_addr   <= d_address;
            lat_wdata  <= d_wdata;
            // A simultaneous read+write is treated as a writeback.
            lat_write  <= d_write;
          end else if (grant_i) begin
            state      <= SERVE_I;
            last_grant <= 1'b0;
            lat_addr   <= i_address;
            // Write data register is left alone: the I side never writes,
            // and the adaptor keeps seeing the last D write line.
            lat_write  <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Adaptor side: driven purely from registers so requester inputs can move
  // freely during a burst without disturbing it.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (state != IDLE);
    pmem_read    = busy & ~lat_write;
    pmem_write   = busy &  lat_write;
    pmem_address = lat_addr;
    pmem_wdata   = lat_wdata;
  end

  // ---------------------------------------------------------------------------
  // Requester side: data fans out to both caches; resp is steered by state
  // so it can only ever reach the current owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    i_rdata = pmem_rdata;
    d_rdata = pmem_rdata;
    i_resp  = pmem_resp & (state == SERVE_I);
    d_resp  = pmem_resp & (state == SERVE_D);
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//
// Drives directed scenarios (single I read, tie after reset, write with
// address isolation, read+write collapse, fairness over six bursts, reset in
// the middle of a burst) followed by fully random activity on every input.
// A transaction-level owner model runs alongside and every output is
// compared with it on each falling edge.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read = 1'b0;
  logic [31:0]  i_address = 32'd0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_address = 32'd0;
  logic [255:0] d_wdata = 256'd0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = 256'd0;
  logic         pmem_resp = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: who owns the adaptor and what request was captured.
  // owner: 0 = nobody, 1 = instruction cache, 2 = data cache.
  // ---------------------------------------------------------------------------
  int           m_owner = 0;
  bit           m_d_won_last = 1'b0;
  logic [31:0]  m_addr = 32'd0;
  logic [255:0] m_wdata = 256'd0;
  bit           m_is_write = 1'b0;
  int           m_grants = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner      = 0;
      m_d_won_last = 1'b0;
      m_addr       = 32'd0;
      m_wdata      = 256'd0;
      m_is_write   = 1'b0;
    end else if (m_owner == 0) begin
      if ((d_read || d_write) && (!i_read || !m_d_won_last)) begin
        m_owner      = 2;
        m_d_won_last = 1'b1;
        m_addr       = d_address;
        m_wdata      = d_wdata;
        m_is_write   = d_write;
        m_grants++;
      end else if (i_read) begin
        m_owner      = 1;
        m_d_won_last = 1'b0;
        m_addr       = i_address;
        m_is_write   = 1'b0;
        m_grants++;
      end
    end else if (pmem_resp) begin
      m_owner = 0;
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",         busy,         (m_owner != 0));
      check("pmem_read",    pmem_read,    (m_owner != 0) && !m_is_write);
      check("pmem_write",   pmem_write,   (m_owner == 2) && m_is_write);
      check("pmem_address", pmem_address, m_addr);
      check("pmem_wdata",   pmem_wdata,   m_wdata);
      check("i_resp",       i_resp,       pmem_resp && (m_owner == 1));
      check("d_resp",       d_resp,       pmem_resp && (m_owner == 2));
      check("i_rdata",      i_rdata,      pmem_rdata);
      check("d_rdata",      d_rdata,      pmem_rdata);
    end
  end

  // Grant-order scoreboard: 1 = D expected, 0 = I expected.
  logic [0:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Plays the adaptor: after lat (>=1) cycles pulses pmem_resp for one cycle,
  // returning which resp line the DUT raised.  Optionally drops the served
  // requester in the cycle after its resp.
  task automatic adaptor_burst(input int lat, input logic [255:0] data,
                               input bit drop, output bit gi, output bit gd);
    repeat (lat) tick();
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    @(negedge clk);
    gi = i_resp;
    gd = d_resp;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = rand256();
    if (drop) begin
      if (gi) i_read = 1'b0;
      if (gd) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    tick();
    while (busy !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_busy_timeout", (busy === 1'b1), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit gi, gd;
    logic [255:0] wline;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pmem_read",  pmem_read,    1'b0);
    check("rst_pmem_write", pmem_write,   1'b0);
    check("rst_busy",       busy,         1'b0);
    check("rst_addr",       pmem_address, 32'd0);
    check("rst_wdata",      pmem_wdata,   256'd0);

    // I-only read with a 5-cycle adaptor
    i_read = 1'b1;
    i_address = 32'h0000_0060;
    tick();
    @(negedge clk);
    check("ionly_pmem_read", pmem_read,    1'b1);
    check("ionly_addr",      pmem_address, 32'h60);
    adaptor_burst(5, {32{8'hA5}}, 1'b1, gi, gd);
    check("ionly_i_resp", gi, 1'b1);
    check("ionly_d_resp", gd, 1'b0);
    @(negedge clk);
    check("ionly_read_drop", pmem_read, 1'b0);
    check("ionly_resp_once", i_resp,    1'b0);

    // Tie right after reset: D first, then I after one dead IDLE cycle
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    tick();
    @(negedge clk);
    check("tie_first_addr", pmem_address, 32'h200);
    adaptor_burst(2, rand256(), 1'b1, gi, gd);
    check("tie_first_is_d", {gi, gd}, 2'b01);
    @(negedge clk);
    check("tie_dead_cycle", busy, 1'b0);
    tick();
    @(negedge clk);
    check("tie_second_addr", pmem_address, 32'h100);
    adaptor_burst(3, rand256(), 1'b1, gi, gd);
    check("tie_second_is_i", {gi, gd}, 2'b10);

    // Writeback with the D address moving during the burst
    wline = {8{32'hDEADBEEF}};
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = wline;
    tick();
    @(negedge clk);
    check("wr_pmem_write", pmem_write, 1'b1);
    check("wr_pmem_read",  pmem_read,  1'b0);
    check("wr_wdata",      pmem_wdata, wline);
    d_address = 32'h0000_2000;
    d_wdata = rand256();
    tick();
    @(negedge clk);
    check("wr_isolation", pmem_address, 32'h1000);
    adaptor_burst(3, rand256(), 1'b1, gi, gd);
    check("wr_d_resp", gd, 1'b1);
    @(negedge clk);
    check("wr_resp_single", d_resp,     1'b0);
    check("wr_write_drop",  pmem_write, 1'b0);
    check("wr_wdata_held",  pmem_wdata, wline);

    // Read and write together collapse to a write
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_3000;
    tick();
    @(negedge clk);
    check("rw_pmem_write", pmem_write, 1'b1);
    check("rw_pmem_read",  pmem_read,  1'b0);
    adaptor_burst(1, rand256(), 1'b1, gi, gd);

    // Fairness: both sides hold requests for six bursts
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    i_read = 1'b1; i_address = 32'h0000_0400;
    d_read = 1'b1; d_address = 32'h0000_0500;
    for (int k = 0; k < 6; k++) begin
      logic [0:0] e;
      wait_busy(10);
      adaptor_burst(1 + $urandom_range(0, 3), rand256(), 1'b0, gi, gd);
      e = exp_q.pop_front();
      check("fair_order", gd, e);
      check("fair_one_resp", gi ^ gd, 1'b1);
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();

    // Reset in the middle of an I burst, adaptor answers afterwards
    i_read = 1'b1; i_address = 32'h0000_0080;
    tick();
    tick();
    rst = 1'b1;
    i_read = 1'b0;
    tick();
    rst = 1'b0;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("rstmid_i_resp",    i_resp,    1'b0);
    check("rstmid_pmem_read", pmem_read, 1'b0);
    check("rstmid_busy",      busy,      1'b0);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("rstmid_resp_ignored", busy, 1'b0);
    i_read = 1'b1; i_address = 32'h0000_0600;
    d_read = 1'b1; d_address = 32'h0000_0700;
    tick();
    @(negedge clk);
    check("rstmid_tie_to_d", pmem_address, 32'h700);
    adaptor_burst(2, rand256(), 1'b1, gi, gd);
    check("rstmid_d_served", gd, 1'b1);
    wait_busy(10);
    adaptor_burst(2, rand256(), 1'b1, gi, gd);
    check("rstmid_i_served", gi, 1'b1);

    // Random phase: every input free-running, model checks each cycle
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) i_read = ~i_read;
      if ($urandom_range(0, 3) == 0) begin
        d_read  = $urandom_range(0, 1);
        d_write = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 2) == 0) i_address = {$urandom_range(0, 32'h07FF_FFFF), 5'd0};
      if ($urandom_range(0, 2) == 0) d_address = {$urandom_range(0, 32'h07FF_FFFF), 5'd0};
      if ($urandom_range(0, 2) == 0) d_wdata = rand256();
      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = rand256();
    end
    tick();
    check("random_grants_seen", (m_grants > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
REQ-002 clk  in  1  single clock for all logic; rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_read  in  1  instruction-cache line read request.
REQ-005 i_address  in  32  instruction-cache line address (32-byte aligned).
REQ-006 i_rdata  out  256  line data returned to the instruction cache.
REQ-007 i_resp  out  1  one-cycle completion pulse to the instruction cache.
REQ-008 d_read  in  1  data-cache line read request.
REQ-009 d_write  in  1  data-cache line writeback request.
REQ-010 d_address  in  32  data-cache line address (32-byte aligned).
REQ-011 d_wdata  in  256  data-cache writeback line.
REQ-012 d_rdata  out  256  line data returned to the data cache.
REQ-013 d_resp  out  1  one-cycle completion pulse to the data cache.
REQ-014 pmem_read  out  1  line read to the cacheline adaptor.
REQ-015 pmem_write  out  1  line write to the cacheline adaptor.
REQ-016 pmem_address  out  32  line address to the adaptor.
REQ-017 pmem_wdata  out  256  line write data to the adaptor.
REQ-018 pmem_rdata  in  256  line read data from the adaptor.
REQ-019 pmem_resp  in  1  adaptor completion pulse.
REQ-020 busy  out  1  high while any state other than IDLE is active.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-022 A 1-bit register last_grant (0 = I, 1 = D) SHALL record the requester most recently granted.
REQ-023 IDLE transitions:
- Only I requests: go to SERVE_I.
- Only D requests (d_read or d_write): go to SERVE_D.
- Both request: grant the side not equal to last_grant.
- Neither requests: stay in IDLE.
REQ-024 On every IDLE→SERVE_x transition, the arbiter SHALL latch the winner's address, d_wdata (D only) and operation into registers, and SHALL update last_grant.
REQ-025 In SERVE_x, pmem_read, pmem_write, pmem_address and pmem_wdata SHALL be driven only from the latched registers, never combinationally from requester inputs.
REQ-026 Latency: a request sampled in IDLE at edge N SHALL produce pmem_read or pmem_write high during cycle N+1.
REQ-027 In IDLE, pmem_read = pmem_write = 0, and pmem_address and pmem_wdata SHALL hold their last latched values.
REQ-028 If d_read and d_write are both high at grant, the arbiter SHALL latch the request as a write (pmem_write = 1, pmem_read = 0).
REQ-029 pmem_rdata SHALL pass combinationally to both i_rdata and d_rdata at all times.
REQ-030 i_resp SHALL equal pmem_resp AND (state == SERVE_I); d_resp SHALL equal pmem_resp AND (state == SERVE_D); both SHALL be combinational and never high together.
REQ-031 When pmem_resp = 1 in SERVE_x, the next state SHALL be IDLE, and pmem_read/pmem_write SHALL be 0 from the following cycle.
REQ-032 Requesters deassert in the cycle after their resp; IDLE therefore gives at least one dead cycle between back-to-back bursts.
REQ-033 A requester deasserting mid-SERVE SHALL NOT abort the burst; the arbiter SHALL hold until pmem_resp and still pulse that requester's resp.
REQ-034 Input changes on the non-granted side during SERVE_x SHALL have no effect until the FSM returns to IDLE.
REQ-035 pmem_resp while in IDLE SHALL be ignored: no resp output and no state change.
REQ-036 Starvation bound: with both sides requesting continuously, grants SHALL strictly alternate I, D, I, D, ...

Reset
REQ-037 When rst is high at a clock edge, the FSM SHALL go to IDLE and last_grant SHALL be set to 0, so D wins the first tie.
REQ-038 After reset, pmem_read, pmem_write, busy, i_resp and d_resp SHALL be 0; latched address and wdata SHALL be 0.
REQ-039 rst asserted mid-SERVE SHALL abandon the burst; any pmem_resp in the cycle after reset SHALL be ignored.

Verification
REQ-040 I-only: i_read=1, i_address=0x0000_0060; adaptor responds after 5 cycles with pmem_rdata=0xA5..A5 → pmem_read high from cycle 1, pmem_address=0x60, i_resp pulses once with i_rdata=0xA5..A5, d_resp stays 0.
REQ-041 Simultaneous after reset: i_read=1 and d_read=1 in the same cycle → D is served first; I is granted in the IDLE cycle after d_resp; I is served second.
REQ-042 Write: d_write=1, d_address=0x0000_1000, d_wdata=0xDEADBEEF repeated → pmem_write=1, pmem_wdata matches, pmem_read=0; d_resp is a single-cycle pulse.
REQ-043 Isolation: d_address changes to 0x2000 while SERVE_D is active → pmem_address stays 0x1000 until pmem_resp.
REQ-044 Fairness: both sides request continuously for 6 bursts → grant order D, I, D, I, D, I; no more than one burst waits per requester.
REQ-045 Reset mid-burst: rst pulsed during SERVE_I, then pmem_resp arrives → i_resp=0, pmem_read=0 after the reset edge, state is IDLE; a subsequent tie is granted to D.
